// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_unit_pkg : shared types and constants for the PC/fetch unit
// Revision 1.0
// ---------------------------------------------------------------------------
package pc_fetch_unit_pkg;

  localparam int PC_W = 64;
  localparam logic [PC_W-1:0] ALIGN_MASK = 64'h3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
    return (pc & ALIGN_MASK) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_unit_if : instruction-memory and decode-side handshake bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if
  import pc_fetch_unit_pkg::*;
#(
  parameter int INST_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [PC_W-1:0]   CurrentPC;
  logic [INST_W-1:0] Instruction;
  logic [PC_W-1:0]   NextPC;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, CurrentPC, Instruction,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, NextPC
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, CurrentPC, Instruction,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, NextPC
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit_pc_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_register : load-enabled PC register with synchronous reset value
// Revision 1.0
// ---------------------------------------------------------------------------
module pc_register #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             ld_i,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (ld_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;
endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_unit : FETCH/WAIT/ISSUE sequencer presenting one instruction at a time
// Revision 1.0
// ---------------------------------------------------------------------------
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0,
  parameter int              INST_W   = 32
) (
  input  wire logic        CLK,
  input  wire logic        Reset,
  pc_fetch_unit_if.master  bus,
  output logic             fault,
  output logic [31:0]      fetch_count
);
  state_t            state_q;
  logic              req_valid_q;
  logic              inst_valid_q;
  logic              fault_q;
  logic [INST_W-1:0] instr_q;
  logic [31:0]       count_q;
  logic [PC_W-1:0]   pc_q;
  logic              handshake;
  logic              pc_load_d;

  assign handshake = (state_q == ST_ISSUE) && inst_valid_q && bus.inst_ready;
  assign pc_load_d = handshake && pc_aligned(bus.NextPC);

  pc_register #(
    .WIDTH     (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk  (CLK),
    .rst  (Reset),
    .ld_i (pc_load_d),
    .d_i  (bus.NextPC),
    .q_o  (pc_q)
  );

  // Valids are registered alongside the state so they change only with it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= ST_FETCH;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      instr_q      <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.imem_req_ready) begin
            state_q     <= ST_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_q      <= ST_ISSUE;
            instr_q      <= bus.imem_rsp_data;
            inst_valid_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (handshake) begin
            inst_valid_q <= 1'b0;
            count_q      <= count_q + 32'd1;
            if (pc_aligned(bus.NextPC)) begin
              state_q     <= ST_FETCH;
              req_valid_q <= 1'b1;
            end else begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.CurrentPC      = pc_q;
  assign bus.Instruction    = instr_q;
  assign fault              = fault_q;
  assign fetch_count        = count_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit : directed vector table plus reset corner sequences
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        fault;
  logic [31:0] fetch_count;

  int nchecks = 0;
  int nerrs   = 0;

  pc_fetch_unit_if #(.INST_W(32)) bus ();

  pc_fetch_unit #(
    .RESET_PC (64'h0),
    .INST_W   (32)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .bus         (bus),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        inr;
    logic [63:0] npc;
    logic        e_rqv;
    logic [63:0] e_addr;
    logic        e_inv;
    logic [31:0] e_instr;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic rsp, input logic [31:0] data,
                     input logic inr, input logic [63:0] npc,
                     input logic e_rqv, input logic [63:0] e_addr, input logic e_inv,
                     input logic [31:0] e_instr, input logic e_fault, input logic [31:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.data = data; v.inr = inr; v.npc = npc;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_inv = e_inv;
    v.e_instr = e_instr; v.e_fault = e_fault; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] data,
                       input logic inr, input logic [63:0] npc);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = data;
    bus.inst_ready     = inr;
    bus.NextPC         = npc;
  endtask

  task automatic check_all(input int idx, input logic rqv, input logic [63:0] addr,
                           input logic inv, input logic [31:0] instr,
                           input logic flt, input logic [31:0] cnt);
    check("req_valid",   idx, 64'(bus.imem_req_valid), 64'(rqv));
    check("imem_addr",   idx, bus.imem_addr, addr);
    check("CurrentPC",   idx, bus.CurrentPC, addr);
    check("inst_valid",  idx, 64'(bus.inst_valid), 64'(inv));
    check("Instruction", idx, 64'(bus.Instruction), 64'(instr));
    check("fault",       idx, 64'(fault), 64'(flt));
    check("fetch_count", idx, 64'(fetch_count), 64'(cnt));
  endtask

  initial begin
    // Outputs shown at each row reflect state after the previous edge; inputs drive the next.
    add(1,0,32'h0,       0,64'h0,   1,64'h0, 0,32'h0,       0,0);
    add(0,1,32'hF84003E9,0,64'h0,   0,64'h0, 0,32'h0,       0,0);
    add(0,0,32'h0,       1,64'h4,   0,64'h0, 1,32'hF84003E9,0,0);
    for (int i = 0; i < 5; i++)
      add(0,1,32'hDEADBEEF,0,64'h0, 1,64'h4, 0,32'hF84003E9,0,1);
    add(1,0,32'h0,       0,64'h0,   1,64'h4, 0,32'hF84003E9,0,1);
    add(0,0,32'h0,       0,64'h0,   0,64'h4, 0,32'hF84003E9,0,1);
    add(0,1,32'h13,      0,64'h0,   0,64'h4, 0,32'hF84003E9,0,1);
    add(0,0,32'h0,       0,64'h100, 0,64'h4, 1,32'h13,      0,1);
    add(0,1,32'hCAFE,    0,64'h200, 0,64'h4, 1,32'h13,      0,1);
    add(0,0,32'h0,       0,64'h8,   0,64'h4, 1,32'h13,      0,1);
    add(0,0,32'h0,       0,64'h300, 0,64'h4, 1,32'h13,      0,1);
    add(0,0,32'h0,       1,64'h10,  0,64'h4, 1,32'h13,      0,1);
    add(1,0,32'h0,       0,64'h0,   1,64'h10,0,32'h13,      0,2);
    add(0,1,32'hAAAA5555,0,64'h0,   0,64'h10,0,32'h13,      0,2);
    add(0,0,32'h0,       1,64'h40,  0,64'h10,1,32'hAAAA5555,0,2);
    add(1,0,32'h0,       0,64'h0,   1,64'h40,0,32'hAAAA5555,0,3);
    add(0,1,32'h12345678,0,64'h0,   0,64'h40,0,32'hAAAA5555,0,3);
    add(0,0,32'h0,       1,64'h42,  0,64'h40,1,32'h12345678,0,3);
    add(1,1,32'h55,      1,64'h80,  0,64'h40,0,32'h12345678,1,4);
    add(1,1,32'h55,      1,64'h80,  0,64'h40,0,32'h12345678,1,4);

    Reset = 1'b1;
    drive(0, 0, 32'h0, 0, 64'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].inr, tbl[i].npc);
      check_all(i, tbl[i].e_rqv, tbl[i].e_addr, tbl[i].e_inv, tbl[i].e_instr,
                tbl[i].e_fault, tbl[i].e_cnt);
      @(negedge CLK);
    end

    // Reset out of FAULT, then reset mid-WAIT followed by a stale response.
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    drive(1, 0, 32'h0, 0, 64'h0);
    check_all(100, 1, 64'h0, 0, 32'h0, 0, 0);
    @(negedge CLK);
    check_all(101, 0, 64'h0, 0, 32'h0, 0, 0);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    drive(0, 1, 32'hBAD0BAD0, 0, 64'h0);
    check_all(102, 1, 64'h0, 0, 32'h0, 0, 0);
    @(negedge CLK);
    drive(1, 0, 32'h0, 0, 64'h0);
    check_all(103, 1, 64'h0, 0, 32'h0, 0, 0);

    // Reset wins over a same-cycle ISSUE handshake.
    @(negedge CLK);
    drive(0, 1, 32'h77, 0, 64'h0);
    @(negedge CLK);
    check_all(104, 0, 64'h0, 1, 32'h77, 0, 0);
    Reset = 1'b1;
    drive(0, 0, 32'h0, 1, 64'h8);
    @(negedge CLK);
    Reset = 1'b0;
    drive(0, 0, 32'h0, 0, 64'h0);
    check_all(105, 1, 64'h0, 0, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
`default_nettype wire
